// File: rtl/mac_pkg.sv
// Shared constants, arithmetic helpers and the packed-port slice macro for
// the multi-lane MAC datapath.
`ifndef MAC_PKG_SV
`define MAC_PKG_SV

// Lane idx of a packed bus whose lanes are w bits wide.
`define MAC_SLICE(idx, w) [(idx)*(w) +: (w)]

package mac_pkg;

  localparam int MAC_LANES = 4;
  localparam int MAC_DW    = 8;
  localparam int MAC_AW    = 22;
  localparam int MAC_FRAC  = 8;
  localparam int MAC_OW    = 8;
  localparam int MAC_ROUND = 1;

  // Add two values that each fit in aw signed bits, saturating the result
  // to the aw-bit signed range. ovf reports that the clamp engaged.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int                 aw,
                                                 output logic              ovf);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s   = a + b;
    hi  = (64'sd1 <<< (aw - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (aw - 1));
    ovf = 1'b0;
    if (s > hi) begin
      s   = hi;
      ovf = 1'b1;
    end else if (s < lo) begin
      s   = lo;
      ovf = 1'b1;
    end
    return s;
  endfunction

  // Rounding (or truncating) arithmetic shift right by frac, then clamp to
  // the ow-bit signed range, or to [0, max] when relu is set. The wide
  // intermediate keeps the rounding add from wrapping.
  function automatic logic signed [63:0] requant(input logic signed [63:0] s,
                                                 input int                 frac,
                                                 input logic               rnd,
                                                 input int                 ow,
                                                 input logic               relu);
    logic signed [63:0] q;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    q = s;
    if (rnd && (frac > 0)) q = q + (64'sd1 <<< (frac - 1));
    q  = q >>> frac;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = relu ? 64'sd0 : -(64'sd1 <<< (ow - 1));
    if (q > hi) q = hi;
    else if (q < lo) q = lo;
    return q;
  endfunction

endpackage

`endif

// File: rtl/mac_lane.sv
// One MAC lane: S1 term register, S2 saturating accumulator with sticky
// overflow, and the requantised result registers loaded on the last beat.
module mac_lane
  import mac_pkg::*;
#(
  parameter int DW    = MAC_DW,
  parameter int AW    = MAC_AW,
  parameter int FRAC  = MAC_FRAC,
  parameter int OW    = MAC_OW,
  parameter int ROUND = MAC_ROUND
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 s1_load,
  input  logic                 only_add,
  input  logic signed [DW-1:0] din_a,
  input  logic signed [DW-1:0] din_b,
  input  logic                 s2_valid,
  input  logic                 s2_last,
  input  logic                 s2_relu,
  input  logic                 clear,
  output logic signed [OW-1:0] dout,
  output logic signed [AW-1:0] acc_out,
  output logic                 acc_ovf
);

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   a_ext;
  logic signed [AW-1:0]   term_d;
  logic signed [AW-1:0]   term;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   sum;
  logic signed [63:0]     sum_w;
  logic signed [63:0]     q_w;
  logic [OW-1:0]          dq;
  logic                   sat;
  logic                   ovf;
  logic                   unused_hi;

  // Next S1 term and the S2 saturated sum / requantised value.
  always_comb begin
    prod   = din_a * din_b;
    a_ext  = AW'(din_a);
    term_d = only_add ? (a_ext <<< FRAC) : AW'(prod);
    sat    = 1'b0;
    sum_w  = sat_add(64'(acc), 64'(term), AW, sat);
    sum    = sum_w[AW-1:0];
    q_w    = requant(sum_w, FRAC, (ROUND != 0), OW, s2_relu);
    dq     = q_w[OW-1:0];
  end

  // Both helpers return values already clamped into the lane widths.
  assign unused_hi = ^{sum_w[63:AW], q_w[63:OW]};

  // Term capture, accumulate, and emission; clear beats a pending S2 beat.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      term    <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
      dout    <= '0;
      acc_out <= '0;
      acc_ovf <= 1'b0;
    end else begin
      if (s1_load) term <= term_d;
      if (clear) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (s2_valid) begin
        if (s2_last) begin
          acc     <= '0;
          ovf     <= 1'b0;
          acc_out <= sum;
          dout    <= dq;
          acc_ovf <= ovf | sat;
        end else begin
          acc <= sum;
          ovf <= ovf | sat;
        end
      end
    end
  end

endmodule

// File: rtl/mac_lane_array.sv
// Multi-lane signed MAC: shared control pipeline plus LANES mac_lane slices.
module mac_lane_array
  import mac_pkg::*;
#(
  parameter int LANES = MAC_LANES,
  parameter int DW    = MAC_DW,
  parameter int AW    = MAC_AW,
  parameter int FRAC  = MAC_FRAC,
  parameter int OW    = MAC_OW,
  parameter int ROUND = MAC_ROUND
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic                only_add,
  input  logic                relu_en,
  input  logic                clear,
  input  logic [LANES*DW-1:0] din_a,
  input  logic [LANES*DW-1:0] din_b,
  output logic                out_valid,
  output logic [LANES*OW-1:0] dout,
  output logic [LANES*AW-1:0] acc_out,
  output logic [LANES-1:0]    acc_ovf
);

  logic s1_valid;
  logic s1_last;
  logic s1_relu;

  // Control side of S1 and the emission strobe; a clear drops the S1 beat.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_relu   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_last <= in_last;
        s1_relu <= relu_en;
      end
      out_valid <= s1_valid & s1_last & ~clear;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(
      .DW   (DW),
      .AW   (AW),
      .FRAC (FRAC),
      .OW   (OW),
      .ROUND(ROUND)
    ) u_lane (
      .clk     (clk),
      .rstn    (rstn),
      .s1_load (in_valid),
      .only_add(only_add),
      .din_a   (din_a `MAC_SLICE(i, DW)),
      .din_b   (din_b `MAC_SLICE(i, DW)),
      .s2_valid(s1_valid),
      .s2_last (s1_last),
      .s2_relu (s1_relu),
      .clear   (clear),
      .dout    (dout `MAC_SLICE(i, OW)),
      .acc_out (acc_out `MAC_SLICE(i, AW)),
      .acc_ovf (acc_ovf[i])
    );
  end

endmodule

// File: tb/tb_mac_lane_array.sv
// Self-checking bench for mac_lane_array: directed scenarios plus a random
// run scored against a window-level accumulate/requantise model.
module tb_mac_lane_array;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int AW    = 22;
  localparam int OW    = 8;
  localparam longint AMAX = 2097151;
  localparam longint AMIN = -2097152;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_last = 1'b0;
  logic                only_add = 1'b0;
  logic                relu_en = 1'b0;
  logic                clear = 1'b0;
  logic [LANES*DW-1:0] din_a = '0;
  logic [LANES*DW-1:0] din_b = '0;
  logic                out_valid;
  logic [LANES*OW-1:0] dout;
  logic [LANES*AW-1:0] acc_out;
  logic [LANES-1:0]    acc_ovf;
  logic                out_valid_t;
  logic [LANES*OW-1:0] dout_t;
  logic [LANES*AW-1:0] acc_out_t;
  logic [LANES-1:0]    acc_ovf_t;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mac_lane_array #(.LANES(4), .DW(8), .AW(22), .FRAC(8), .OW(8), .ROUND(1)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_last(in_last),
    .only_add(only_add), .relu_en(relu_en), .clear(clear),
    .din_a(din_a), .din_b(din_b), .out_valid(out_valid), .dout(dout),
    .acc_out(acc_out), .acc_ovf(acc_ovf)
  );

  mac_lane_array #(.LANES(4), .DW(8), .AW(22), .FRAC(8), .OW(8), .ROUND(0)) dut_tr (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_last(in_last),
    .only_add(only_add), .relu_en(relu_en), .clear(clear),
    .din_a(din_a), .din_b(din_b), .out_valid(out_valid_t), .dout(dout_t),
    .acc_out(acc_out_t), .acc_ovf(acc_ovf_t)
  );

  function automatic logic [31:0] pk(input int x0, input int x1, input int x2, input int x3);
    return {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
  endfunction

  function automatic int dl(input logic [31:0] d, input int i);
    return int'($signed(d[i*8 +: 8]));
  endfunction

  function automatic int al(input logic [87:0] a, input int i);
    return int'($signed(a[i*22 +: 22]));
  endfunction

  // Expected output: round half up (or floor), then clamp.
  function automatic int rq(input longint s, input bit relu, input bit rnd);
    longint q;
    q = (s + (rnd ? 128 : 0)) >>> 8;
    if (q > 127) q = 127;
    if (relu && q < 0) q = 0;
    if (!relu && q < -128) q = -128;
    return int'(q);
  endfunction

  // Present one cycle of inputs at a falling edge; returns at the next one.
  task automatic drive(input logic v, input logic l, input logic oa, input logic r,
                       input logic c, input logic [31:0] a, input logic [31:0] b);
    in_valid = v; in_last = l; only_add = oa; relu_en = r; clear = c;
    din_a = a; din_b = b;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle(); idle();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (dout !== '0) $display("FAIL reset_dout got %h want 0", dout); else passed++;
    total++; if (acc_out !== '0) $display("FAIL reset_acc_out got %h want 0", acc_out); else passed++;
    total++; if (acc_ovf !== '0) $display("FAIL reset_acc_ovf got %b want 0", acc_ovf); else passed++;
    rstn = 1'b1;
    idle();
  endtask

  task automatic test_add_basic();
    drive(1, 1, 1, 0, 0, pk(5, 0, 0, 0), 32'd0);
    total++; if (out_valid !== 1'b0) $display("FAIL add_early_valid got %b want 0", out_valid); else passed++;
    idle();
    total++; if (out_valid !== 1'b1) $display("FAIL add_valid got %b want 1", out_valid); else passed++;
    total++; if (dl(dout, 0) !== 5) $display("FAIL add_dout got %0d want 5", dl(dout, 0)); else passed++;
    total++; if (al(acc_out, 0) !== 1280) $display("FAIL add_acc got %0d want 1280", al(acc_out, 0)); else passed++;
    idle();
    total++; if (out_valid !== 1'b0) $display("FAIL add_pulse_len got %b want 0", out_valid); else passed++;
    total++; if (dl(dout, 0) !== 5) $display("FAIL add_hold got %0d want 5", dl(dout, 0)); else passed++;
  endtask

  task automatic test_mac_relu();
    drive(1, 0, 0, 0, 0, pk(16, 0, 0, 0), pk(16, 0, 0, 0));
    drive(1, 1, 0, 0, 0, pk(-16, 0, 0, 0), pk(16, 0, 0, 0));
    idle();
    total++; if (out_valid !== 1'b1) $display("FAIL mac_valid got %b want 1", out_valid); else passed++;
    total++; if (al(acc_out, 0) !== 0) $display("FAIL mac_acc got %0d want 0", al(acc_out, 0)); else passed++;
    total++; if (dl(dout, 0) !== 0) $display("FAIL mac_dout got %0d want 0", dl(dout, 0)); else passed++;
    drive(1, 1, 0, 0, 0, pk(-16, 0, 0, 0), pk(16, 0, 0, 0));
    idle();
    total++; if (dl(dout, 0) !== -1) $display("FAIL neg_dout got %0d want -1", dl(dout, 0)); else passed++;
    drive(1, 1, 0, 1, 0, pk(-16, 0, 0, 0), pk(16, 0, 0, 0));
    idle();
    total++; if (dl(dout, 0) !== 0) $display("FAIL relu_dout got %0d want 0", dl(dout, 0)); else passed++;
    total++; if (al(acc_out, 0) !== -256) $display("FAIL relu_acc got %0d want -256", al(acc_out, 0)); else passed++;
  endtask

  task automatic test_clamp_round();
    drive(1, 0, 1, 0, 0, pk(127, 0, 0, 0), 32'd0);
    drive(1, 1, 1, 0, 0, pk(127, 0, 0, 0), 32'd0);
    idle();
    total++; if (al(acc_out, 0) !== 65024) $display("FAIL clamp_acc got %0d want 65024", al(acc_out, 0)); else passed++;
    total++; if (dl(dout, 0) !== 127) $display("FAIL clamp_dout got %0d want 127", dl(dout, 0)); else passed++;
    total++; if (acc_ovf[0] !== 1'b0) $display("FAIL clamp_ovf got %b want 0", acc_ovf[0]); else passed++;
    drive(1, 1, 0, 0, 0, pk(8, 0, 0, 0), pk(16, 0, 0, 0));
    idle();
    total++; if (al(acc_out, 0) !== 128) $display("FAIL round_acc got %0d want 128", al(acc_out, 0)); else passed++;
    total++; if (dl(dout, 0) !== 1) $display("FAIL round_dout got %0d want 1", dl(dout, 0)); else passed++;
    total++; if (out_valid_t !== 1'b1) $display("FAIL trunc_valid got %b want 1", out_valid_t); else passed++;
    total++; if (dl(dout_t, 0) !== 0) $display("FAIL trunc_dout got %0d want 0", dl(dout_t, 0)); else passed++;
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 69; n++) drive(1, 0, 1, 0, 0, pk(127, 0, 0, 0), 32'd0);
    drive(1, 1, 1, 0, 0, pk(127, 0, 0, 0), 32'd0);
    drive(1, 1, 1, 0, 0, pk(1, 0, 0, 0), 32'd0);
    total++; if (out_valid !== 1'b1) $display("FAIL sat_valid got %b want 1", out_valid); else passed++;
    total++; if (al(acc_out, 0) !== 2097151) $display("FAIL sat_acc got %0d want 2097151", al(acc_out, 0)); else passed++;
    total++; if (acc_ovf[0] !== 1'b1) $display("FAIL sat_ovf got %b want 1", acc_ovf[0]); else passed++;
    total++; if (dl(dout, 0) !== 127) $display("FAIL sat_dout got %0d want 127", dl(dout, 0)); else passed++;
    idle();
    total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid got %b want 1", out_valid); else passed++;
    total++; if (acc_ovf[0] !== 1'b0) $display("FAIL b2b_ovf got %b want 0", acc_ovf[0]); else passed++;
    total++; if (dl(dout, 0) !== 1) $display("FAIL b2b_dout got %0d want 1", dl(dout, 0)); else passed++;
    total++; if (al(acc_out, 0) !== 256) $display("FAIL b2b_acc got %0d want 256", al(acc_out, 0)); else passed++;
    idle();
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_end got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_clear();
    drive(1, 0, 1, 0, 0, pk(9, 0, 0, 0), 32'd0);
    drive(1, 1, 1, 0, 0, pk(5, 0, 0, 0), 32'd0);
    drive(1, 0, 1, 0, 1, pk(3, 0, 0, 0), 32'd0);
    total++; if (out_valid !== 1'b0) $display("FAIL clear_drop got %b want 0", out_valid); else passed++;
    drive(1, 1, 1, 0, 0, pk(4, 0, 0, 0), 32'd0);
    total++; if (out_valid !== 1'b0) $display("FAIL clear_idle got %b want 0", out_valid); else passed++;
    idle();
    total++; if (out_valid !== 1'b1) $display("FAIL clear_next_valid got %b want 1", out_valid); else passed++;
    total++; if (al(acc_out, 0) !== 1792) $display("FAIL clear_acc got %0d want 1792", al(acc_out, 0)); else passed++;
    total++; if (dl(dout, 0) !== 7) $display("FAIL clear_dout got %0d want 7", dl(dout, 0)); else passed++;
  endtask

  task automatic test_reset_mid();
    int ed[4];
    int ea[4];
    drive(1, 0, 1, 0, 0, pk(50, 50, 50, 50), 32'd0);
    drive(1, 1, 1, 0, 0, pk(9, 9, 9, 9), 32'd0);
    rstn = 1'b0;
    idle();
    rstn = 1'b1;
    total++; if (out_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", out_valid); else passed++;
    total++; if (acc_out !== '0) $display("FAIL rmid_acc got %h want 0", acc_out); else passed++;
    drive(1, 1, 1, 0, 0, pk(2, 100, -128, -50), 32'd0);
    idle();
    ed = '{2, 100, -128, -50};
    ea = '{512, 25600, -32768, -12800};
    total++; if (out_valid !== 1'b1) $display("FAIL rmid_new_valid got %b want 1", out_valid); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (dl(dout, i) !== ed[i]) $display("FAIL rmid_dout lane%0d got %0d want %0d", i, dl(dout, i), ed[i]); else passed++;
      total++; if (al(acc_out, i) !== ea[i]) $display("FAIL rmid_acc lane%0d got %0d want %0d", i, al(acc_out, i), ea[i]); else passed++;
    end
  endtask

  typedef struct {
    int          due;
    logic [31:0] d;
    logic [87:0] a;
    logic [3:0]  o;
  } exp_t;

  task automatic test_random();
    exp_t        q[$];
    exp_t        e;
    longint      macc[4];
    bit          movf[4];
    bit          pv, pl, pr, poa;
    logic [31:0] pa, pb, a, b;
    logic        v, l, oa, r, c, exp_v;
    logic [31:0] last_d;
    logic [87:0] last_a;
    logic [3:0]  last_o;
    rstn = 1'b0;
    idle();
    rstn = 1'b1;
    idle();
    for (int i = 0; i < 4; i++) begin macc[i] = 0; movf[i] = 0; end
    pv = 0; pl = 0; pr = 0; poa = 0; pa = 0; pb = 0;
    last_d = '0; last_a = '0; last_o = '0;
    for (int k = 0; k < 400; k++) begin
      exp_v = 1'b0;
      if (q.size() > 0 && q[0].due == k) begin
        e = q.pop_front();
        exp_v = 1'b1;
        last_d = e.d; last_a = e.a; last_o = e.o;
      end
      total++; if (out_valid !== exp_v) $display("FAIL rnd_valid cyc%0d got %b want %b", k, out_valid, exp_v); else passed++;
      total++;
      if (dout !== last_d || acc_out !== last_a || acc_ovf !== last_o)
        $display("FAIL rnd_data cyc%0d got %h/%h/%b want %h/%h/%b", k, dout, acc_out, acc_ovf, last_d, last_a, last_o);
      else passed++;
      v  = ($urandom_range(0, 9) < 8);
      l  = ($urandom_range(0, 4) == 0);
      oa = ($urandom_range(0, 2) == 0);
      r  = $urandom_range(0, 1) == 1;
      c  = ($urandom_range(0, 24) == 0);
      a  = $urandom;
      b  = $urandom;
      if (k >= 395) begin v = 0; c = 0; end
      if (c) begin
        for (int i = 0; i < 4; i++) begin macc[i] = 0; movf[i] = 0; end
      end else if (pv) begin
        for (int i = 0; i < 4; i++) begin
          longint sa, sb, t, s;
          sa = longint'($signed(pa[i*8 +: 8]));
          sb = longint'($signed(pb[i*8 +: 8]));
          t  = poa ? sa * 256 : sa * sb;
          s  = macc[i] + t;
          if (s > AMAX) begin s = AMAX; movf[i] = 1; end
          else if (s < AMIN) begin s = AMIN; movf[i] = 1; end
          macc[i] = s;
        end
        if (pl) begin
          e.due = k + 1;
          for (int i = 0; i < 4; i++) begin
            int rv;
            rv = rq(macc[i], pr, 1'b1);
            e.d[i*8 +: 8]   = rv[7:0];
            e.a[i*22 +: 22] = macc[i][21:0];
            e.o[i]          = movf[i];
            macc[i] = 0;
            movf[i] = 0;
          end
          q.push_back(e);
        end
      end
      pv = v; pl = l; pr = r; poa = oa; pa = a; pb = b;
      drive(v, l, oa, r, c, a, b);
    end
    total++; if (q.size() != 0) $display("FAIL rnd_drain got %0d pending want 0", q.size()); else passed++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout reached, bench did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_add_basic();
    test_mac_relu();
    test_clamp_round();
    test_saturation();
    test_clear();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
